// File: rtl/tbuf_pkg.sv
// -----------------------------------------------------------------------------
// tbuf_pkg
// Shared types and helpers for the transmit frame buffer.
//   tbuf_state_e : FSM state encoding (frame filling vs. frame draining)
//   popcount     : counts written slots for the occupancy output
//   tbuf_idx_w   : slot index width for a given depth
//   tbuf_lvl_w   : occupancy width for a given depth (must hold DEPTH itself)
// -----------------------------------------------------------------------------
package tbuf_pkg;

    typedef enum logic {
        TBUF_FILL  = 1'b0,
        TBUF_DRAIN = 1'b1
    } tbuf_state_e;

    // Widest slot mask the popcount helper accepts.
    localparam int TBUF_MAX_DEPTH = 64;

    localparam int TBUF_DEF_DEPTH = 4;
    localparam int TBUF_DEF_IDX_W = $clog2(TBUF_DEF_DEPTH);
    localparam int TBUF_DEF_LVL_W = TBUF_DEF_IDX_W + 1;

    function automatic int tbuf_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tbuf_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned popcount(input logic [TBUF_MAX_DEPTH-1:0] bits);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < TBUF_MAX_DEPTH; i++) begin
            cnt += int'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tbuf_storage.sv
// -----------------------------------------------------------------------------
// tbuf_storage
// DEPTH x DATA_W slot register array for the transmit frame buffer.
//   clk, reset : clock and asynchronous active-high reset (clears all slots)
//   we, w_idx, w_data : indexed slot write
//   clear      : synchronous clear of every slot (frame reopened)
//   r_idx, r_data : combinational indexed read
//   contents   : flattened slot array, slot 0 in LSBs (only with TBUF_DEBUG_EN)
// -----------------------------------------------------------------------------
module tbuf_storage
    import tbuf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = TBUF_DEF_DEPTH,
    localparam int IDX_W = tbuf_idx_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [IDX_W-1:0]        w_idx,
    input  logic [DATA_W-1:0]       w_data,
    input  logic                    clear,
    input  logic [IDX_W-1:0]        r_idx,
`ifdef TBUF_DEBUG_EN
    output logic [DEPTH*DATA_W-1:0] contents,
`endif
    output logic [DATA_W-1:0]       r_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: this array is reset and cleared on purpose -- slots skipped by the
    // CPU must read back as zero; sequential state uses non-blocking '<='.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[w_idx] <= w_data;
        end
    end

    assign r_data = mem[r_idx];

`ifdef TBUF_DEBUG_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign contents[g*DATA_W +: DATA_W] = mem[g];
    end
`endif

endmodule

// File: rtl/tx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tx_frame_buffer
// Frame-oriented transmit buffer between the CPU write path and the UART TX.
// The CPU fills address-mapped slots; the frame commits when every slot is
// written or on 'commit', then drains in slot order under 'rd'.
// Optional feature macro: TBUF_DEBUG_EN adds the dbg_buffer port.
//   clk, reset        : clock, asynchronous active-high reset
//   wr, address, w_data : CPU write strobe/address/data
//   commit            : close a non-empty frame early
//   rd                : transmitter consumed r_data
//   r_data, valid     : word at read pointer, valid while draining
//   full, empty       : frame committed / no slot written yet
//   level             : written slots (fill) or words left (drain)
//   wr_drop           : one-cycle pulse after a write discarded while full
//   dbg_buffer        : slot contents, slot 0 in LSBs (TBUF_DEBUG_EN only)
// -----------------------------------------------------------------------------
module tx_frame_buffer
    import tbuf_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = TBUF_DEF_DEPTH,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 6,
    localparam int IDX_W    = tbuf_idx_w(DEPTH),
    localparam int LVL_W    = tbuf_lvl_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       w_data,
    input  logic                    commit,
    input  logic                    rd,
    output logic [DATA_W-1:0]       r_data,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic [LVL_W-1:0]        level,
`ifdef TBUF_DEBUG_EN
    output logic [DEPTH*DATA_W-1:0] dbg_buffer,
`endif
    output logic                    wr_drop
);

    // One extra address bit so BASE_ADDR+DEPTH never wraps in the compare.
    localparam logic [ADDR_W:0] SLOT_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] SLOT_HI = (ADDR_W+1)'(BASE_ADDR + DEPTH);

    tbuf_state_e       state, state_nxt;
    logic [DEPTH-1:0]  wmask, wmask_nxt, wr_onehot, fill_mask;
    logic [LVL_W-1:0]  len, len_nxt, fill_len;
    logic [IDX_W-1:0]  r_ptr, r_ptr_nxt, wr_idx;
    logic [ADDR_W:0]   addr_ext;
    logic              in_range, store_en, clear_all, last_rd, wr_drop_nxt;
    logic [DATA_W-1:0] slot_data;

    assign addr_ext  = {1'b0, address};
    assign in_range  = (addr_ext >= SLOT_LO) && (addr_ext < SLOT_HI);
    assign wr_idx    = IDX_W'(addr_ext - SLOT_LO);
    assign wr_onehot = DEPTH'(1) << wr_idx;
    assign last_rd   = ({1'b0, r_ptr} + LVL_W'(1)) == len;

    // Mask including a same-cycle write, so a write plus commit in one cycle
    // (or the write that completes the mask) yields the correct frame length.
    always_comb begin
        fill_mask = wmask;
        if (wr && in_range) begin
            fill_mask = wmask | wr_onehot;
        end
        fill_len = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_mask[i]) begin
                fill_len = LVL_W'(i + 1);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        wmask_nxt   = wmask;
        len_nxt     = len;
        r_ptr_nxt   = r_ptr;
        store_en    = 1'b0;
        clear_all   = 1'b0;
        wr_drop_nxt = 1'b0;
        full        = 1'b0;
        valid       = 1'b0;
        empty       = 1'b0;
        r_data      = '0;
        level       = '0;

        case (state)
            TBUF_FILL: begin
                store_en  = wr && in_range;
                wmask_nxt = fill_mask;
                if ((&fill_mask) || (commit && (|fill_mask))) begin
                    state_nxt = TBUF_DRAIN;
                    len_nxt   = fill_len;
                end
                empty = (wmask == '0);
                level = LVL_W'(popcount(TBUF_MAX_DEPTH'(wmask)));
            end
            TBUF_DRAIN: begin
                wr_drop_nxt = wr && in_range;
                if (rd) begin
                    if (last_rd) begin
                        state_nxt = TBUF_FILL;
                        wmask_nxt = '0;
                        r_ptr_nxt = '0;
                        clear_all = 1'b1;
                    end else begin
                        r_ptr_nxt = r_ptr + 1'b1;
                    end
                end
                full   = 1'b1;
                valid  = 1'b1;
                r_data = slot_data;
                level  = len - {1'b0, r_ptr};
            end
            default: begin
                state_nxt = TBUF_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TBUF_FILL;
            wmask   <= '0;
            len     <= '0;
            r_ptr   <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            wmask   <= wmask_nxt;
            len     <= len_nxt;
            r_ptr   <= r_ptr_nxt;
            wr_drop <= wr_drop_nxt;
        end
    end

    tbuf_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk      (clk),
        .reset    (reset),
        .we       (store_en),
        .w_idx    (wr_idx),
        .w_data   (w_data),
        .clear    (clear_all),
        .r_idx    (r_ptr),
`ifdef TBUF_DEBUG_EN
        .contents (dbg_buffer),
`endif
        .r_data   (slot_data)
    );

endmodule

// File: tb/tb_tx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_buffer
// Directed bench for tx_frame_buffer: one instance with default parameters and
// one with DEPTH=8, DATA_W=16, BASE_ADDR=0. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_tx_frame_buffer;

    logic        clk;
    logic        reset;

    // default instance
    logic        wr, commit, rd;
    logic [3:0]  address;
    logic [7:0]  w_data;
    logic [7:0]  r_data;
    logic        valid, full, empty, wr_drop;
    logic [2:0]  level;

    // DEPTH=8 / DATA_W=16 / BASE_ADDR=0 instance
    logic        wr8, commit8, rd8;
    logic [3:0]  address8;
    logic [15:0] w_data8;
    logic [15:0] r_data8;
    logic        valid8, full8, empty8, wr_drop8;
    logic [3:0]  level8;

`ifdef TBUF_DEBUG_EN
    logic [31:0]  dbg;
    logic [127:0] dbg8;
`endif

    int total = 0;
    int bad   = 0;

    tx_frame_buffer dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .address (address),
        .w_data  (w_data),
        .commit  (commit),
        .rd      (rd),
        .r_data  (r_data),
        .valid   (valid),
        .full    (full),
        .empty   (empty),
        .level   (level),
`ifdef TBUF_DEBUG_EN
        .dbg_buffer (dbg),
`endif
        .wr_drop (wr_drop)
    );

    tx_frame_buffer #(
        .DATA_W    (16),
        .DEPTH     (8),
        .ADDR_W    (4),
        .BASE_ADDR (0)
    ) dut8 (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr8),
        .address (address8),
        .w_data  (w_data8),
        .commit  (commit8),
        .rd      (rd8),
        .r_data  (r_data8),
        .valid   (valid8),
        .full    (full8),
        .empty   (empty8),
        .level   (level8),
`ifdef TBUF_DEBUG_EN
        .dbg_buffer (dbg8),
`endif
        .wr_drop (wr_drop8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] a, input logic [7:0] d);
        wr      = 1'b1;
        address = a;
        w_data  = d;
        step();
        wr      = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr = 1'b0; commit = 1'b0; rd = 1'b0; address = '0; w_data = '0;
        wr8 = 1'b0; commit8 = 1'b0; rd8 = 1'b0; address8 = '0; w_data8 = '0;
        #2;
        check("rst_r_data",  r_data,  8'h00);
        check("rst_valid",   valid,   1'b0);
        check("rst_full",    full,    1'b0);
        check("rst_empty",   empty,   1'b1);
        check("rst_level",   level,   3'd0);
        check("rst_wr_drop", wr_drop, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // full frame of four writes, then four reads
        put(4'd6, 8'h41);
        check("t1_level1", level, 3'd1);
        check("t1_empty0", empty, 1'b0);
        put(4'd7, 8'h42);
        put(4'd8, 8'h43);
        check("t1_full_early", full, 1'b0);
        put(4'd9, 8'h44);
        check("t1_full",   full,   1'b1);
        check("t1_valid",  valid,  1'b1);
        check("t1_rdata0", r_data, 8'h41);
        check("t1_level4", level,  3'd4);
        pulse_rd();
        check("t1_rdata1", r_data, 8'h42);
        check("t1_level3", level,  3'd3);
        pulse_rd();
        check("t1_rdata2", r_data, 8'h43);
        pulse_rd();
        check("t1_rdata3", r_data, 8'h44);
        check("t1_level1d", level, 3'd1);
        pulse_rd();
        check("t1_end_full",  full,   1'b0);
        check("t1_end_empty", empty,  1'b1);
        check("t1_end_level", level,  3'd0);
        check("t1_end_valid", valid,  1'b0);
        check("t1_end_rdata", r_data, 8'h00);

        // single write to slot 1, early commit: gap slot 0 reads as zero
        put(4'd7, 8'h55);
        check("t2_level1", level, 3'd1);
        rd = 1'b1;                      // rd while filling is ignored
        step();
        rd = 1'b0;
        check("t2_rd_fill_level", level, 3'd1);
        check("t2_rd_fill_full",  full,  1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("t2_full",   full,   1'b1);
        check("t2_len",    level,  3'd2);
        check("t2_rdata0", r_data, 8'h00);
        pulse_rd();
        check("t2_rdata1", r_data, 8'h55);
        check("t2_level1d", level, 3'd1);
        pulse_rd();
        check("t2_end_empty", empty, 1'b1);

        // commit on an empty frame is ignored
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("t2b_empty_commit_full", full, 1'b0);

        // rewrite of one slot counts once, last value wins
        put(4'd7, 8'h10);
        put(4'd7, 8'h20);
        check("t3_level", level, 3'd1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("t3_full",   full,   1'b1);
        check("t3_rdata0", r_data, 8'h00);
        pulse_rd();
        check("t3_rdata1", r_data, 8'h20);
        pulse_rd();
        check("t3_end_empty", empty, 1'b1);

        // write while full is dropped; out-of-range write while filling ignored
        put(4'd6, 8'hA1);
        put(4'd7, 8'hA2);
        put(4'd8, 8'hA3);
        put(4'd9, 8'hA4);
        check("t4_full", full, 1'b1);
        put(4'd8, 8'hFF);
        check("t4_wr_drop",  wr_drop, 1'b1);
        check("t4_rdata0",   r_data,  8'hA1);
        check("t4_level",    level,   3'd4);
        step();
        check("t4_wr_drop_gone", wr_drop, 1'b0);
        pulse_rd();
        check("t4_rdata1", r_data, 8'hA2);
        pulse_rd();
        check("t4_rdata2", r_data, 8'hA3);
        pulse_rd();
        check("t4_rdata3", r_data, 8'hA4);
        pulse_rd();
        check("t4_end_empty", empty, 1'b1);
        put(4'd12, 8'h77);
        check("t4_oor_hi_drop",  wr_drop, 1'b0);
        check("t4_oor_hi_empty", empty,   1'b1);
        put(4'd5, 8'h78);
        check("t4_oor_lo_level", level,   3'd0);
        check("t4_oor_lo_drop",  wr_drop, 1'b0);

        // reset in the middle of a drain
        put(4'd6, 8'hB1);
        put(4'd7, 8'hB2);
        put(4'd8, 8'hB3);
        put(4'd9, 8'hB4);
        pulse_rd();
        pulse_rd();
        check("t5_rdata2", r_data, 8'hB3);
        reset = 1'b1;
        #1;
        check("t5_rst_full",   full,    1'b0);
        check("t5_rst_valid",  valid,   1'b0);
        check("t5_rst_empty",  empty,   1'b1);
        check("t5_rst_level",  level,   3'd0);
        check("t5_rst_rdata",  r_data,  8'h00);
        check("t5_rst_wrdrop", wr_drop, 1'b0);
        #2;
        reset = 1'b0;
        step();
        put(4'd6, 8'hC1);
        put(4'd7, 8'hC2);
        put(4'd8, 8'hC3);
        put(4'd9, 8'hC4);
        check("t5_new_full",   full,   1'b1);
        check("t5_new_rdata0", r_data, 8'hC1);
        pulse_rd();
        check("t5_new_rdata1", r_data, 8'hC2);
        pulse_rd();
        check("t5_new_rdata2", r_data, 8'hC3);
        pulse_rd();
        check("t5_new_rdata3", r_data, 8'hC4);
        pulse_rd();
        check("t5_new_empty",  empty,  1'b1);

        // 8-deep, 16-bit instance: last write coincides with commit
        for (int i = 0; i < 7; i++) begin
            wr8      = 1'b1;
            address8 = 4'(i);
            w_data8  = 16'h1000 + 16'(i);
            step();
        end
        wr8 = 1'b0;
        check("t6_level7", level8, 4'd7);
        check("t6_full_early", full8, 1'b0);
        wr8      = 1'b1;
        address8 = 4'd7;
        w_data8  = 16'h1007;
        commit8  = 1'b1;
        step();
        wr8     = 1'b0;
        commit8 = 1'b0;
        check("t6_full",   full8,   1'b1);
        check("t6_len",    level8,  4'd8);
        check("t6_rdata0", r_data8, 16'h1000);
        step();
        check("t6_len_hold", level8, 4'd8);
        for (int i = 1; i < 8; i++) begin
            rd8 = 1'b1;
            step();
            rd8 = 1'b0;
            check($sformatf("t6_rdata%0d", i), r_data8, 16'h1000 + 16'(i));
            check($sformatf("t6_level%0d", i), level8, 4'(8 - i));
        end
        rd8 = 1'b1;
        step();
        rd8 = 1'b0;
        check("t6_end_empty", empty8, 1'b1);
        check("t6_end_full",  full8,  1'b0);
        check("t6_end_level", level8, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
